// File: rtl/reg_move_sequencer.sv
// rtl/reg_move_sequencer.sv - relay-safe MOV/clear sequencer driving register-unit sel/ld lines
module reg_move_sequencer #(
    parameter int SETTLE = 2,
    parameter int LOAD   = 1,
    parameter int HOLD   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_src,
    input  logic [2:0]  req_dst,
    input  logic        req_clr,
    output logic [7:0]  sel_o,
    output logic [7:0]  ld_o,
    output logic        clr_o,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] led_o
);
    localparam int MAX_SL = (SETTLE > LOAD) ? SETTLE : LOAD;
    localparam int MAX_PH = (MAX_SL > HOLD) ? MAX_SL : HOLD;
    localparam int CW     = $clog2(MAX_PH + 1);

    typedef enum logic [2:0] {IDLE, SEL, LD, HLD, ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    src_q, src_d, dst_q, dst_d;
    logic          clrm_q, clrm_d;

    logic          ready_q, ready_d;
    logic [7:0]    sel_q, sel_d, ld_q, ld_d;
    logic          clr_q, clr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        clrm_d  = clrm_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    src_d  = req_src;
                    dst_d  = req_dst;
                    clrm_d = req_clr;
                    if (!req_clr && (req_src == req_dst)) begin
                        state_d = ERR;
                    end else begin
                        state_d = SEL;
                        cnt_d   = CW'(SETTLE - 1);
                    end
                end
            end
            SEL: begin
                if (cnt_q == '0) begin
                    state_d = LD;
                    cnt_d   = CW'(LOAD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LD: begin
                if (cnt_q == '0) begin
                    state_d = HLD;
                    cnt_d   = CW'(HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so every output leaves a flop.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SEL) || (state_d == LD) || (state_d == HLD);
        sel_d   = (busy_d && !clrm_d) ? (8'd1 << src_d) : 8'd0;
        clr_d   = busy_d && clrm_d;
        ld_d    = (state_d == LD) ? (8'd1 << dst_d) : 8'd0;
        done_d  = (state_d == HLD) && (cnt_d == '0);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            clrm_q  <= 1'b0;
            ready_q <= 1'b1;
            sel_q   <= '0;
            ld_q    <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            clrm_q  <= clrm_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
            ld_q    <= ld_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign sel_o     = sel_q;
    assign ld_o      = ld_q;
    assign clr_o     = clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign led_o     = {ld_q, sel_q};
endmodule

// File: tb/tb_reg_move_sequencer.sv
// tb/tb_reg_move_sequencer.sv - vector-table and sequence checks for reg_move_sequencer
module tb_reg_move_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    logic        rst0, v0, c0, rdy0, clro0, busy0, done0, err0;
    logic [2:0]  s0, d0;
    logic [7:0]  sel0, ld0;
    logic [15:0] led0;
    logic        rst1, v1, c1, rdy1, clro1, busy1, done1, err1;
    logic [2:0]  s1, d1;
    logic [7:0]  sel1, ld1;
    logic [15:0] led1;

    reg_move_sequencer u_dut0 (
        .clk(clk), .reset(rst0), .req_valid(v0), .req_ready(rdy0),
        .req_src(s0), .req_dst(d0), .req_clr(c0),
        .sel_o(sel0), .ld_o(ld0), .clr_o(clro0), .busy(busy0),
        .done(done0), .err(err0), .led_o(led0)
    );

    reg_move_sequencer #(.SETTLE(3), .LOAD(2), .HOLD(2)) u_dut1 (
        .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1),
        .req_src(s1), .req_dst(d1), .req_clr(c1),
        .sel_o(sel1), .ld_o(ld1), .clr_o(clro1), .busy(busy1),
        .done(done1), .err(err1), .led_o(led1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] sel, input logic [7:0] ld, input logic clr,
                                         input logic bsy, input logic dn, input logic er, input logic rdy);
        return {11'd0, sel, ld, clr, bsy, dn, er, rdy};
    endfunction

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic [2:0] d;
        logic       c;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] s, input logic [2:0] d, input logic c,
                                input logic [7:0] sel, input logic [7:0] ld, input logic clr,
                                input logic bsy, input logic dn, input logic er, input logic rdy);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.c = c;
        r.exp = pack(sel, ld, clr, bsy, dn, er, rdy);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Invariant monitors: one-hot, sel/clr exclusion, settle time, LED mirror.
    logic mon0 = 1'b0, mon1 = 1'b0;
    int   run0 = 0, run1 = 0;
    always @(negedge clk) begin
        if (mon0) begin
            chk("onehot_sel0", 32'($onehot0(sel0)), 32'd1);
            chk("onehot_ld0", 32'($onehot0(ld0)), 32'd1);
            chk("sel_clr_excl0", 32'((sel0 != 8'd0) && clro0), 32'd0);
            chk("led_mirror0", 32'(led0), 32'({ld0, sel0}));
            if (ld0 != 8'd0) chk("settle0", 32'(run0 >= 2), 32'd1);
            run0 = ((sel0 != 8'd0) || clro0) ? run0 + 1 : 0;
        end
        if (mon1) begin
            chk("onehot_sel1", 32'($onehot0(sel1)), 32'd1);
            chk("onehot_ld1", 32'($onehot0(ld1)), 32'd1);
            chk("sel_clr_excl1", 32'((sel1 != 8'd0) && clro1), 32'd0);
            chk("led_mirror1", 32'(led1), 32'({ld1, sel1}));
            if (ld1 != 8'd0) chk("settle1", 32'(run1 >= 3), 32'd1);
            run1 = ((sel1 != 8'd0) || clro1) ? run1 + 1 : 0;
        end
    end

    vec_t tbl[17];

    initial begin
        //            v  src dst clr  sel    ld     clr bsy dn er rdy
        tbl[0]  = mk(1, 1, 0, 0, 8'h02, 8'h00, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 8'h02, 8'h00, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 6, 4, 0, 8'h02, 8'h01, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 6, 4, 0, 8'h02, 8'h00, 0, 1, 1, 0, 0);
        tbl[4]  = mk(1, 6, 4, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 7, 7, 1, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 8'h00, 8'h80, 1, 1, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        tbl[10] = mk(1, 3, 3, 0, 8'h00, 8'h00, 0, 0, 0, 1, 0);
        tbl[11] = mk(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 0, 1, 0, 8'h01, 8'h00, 0, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 8'h01, 8'h00, 0, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 8'h01, 8'h02, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 8'h01, 8'h00, 0, 1, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);

        rst0 = 1'b1; v0 = 1'b0; s0 = 3'd0; d0 = 3'd0; c0 = 1'b0;
        rst1 = 1'b1; v1 = 1'b0; s1 = 3'd0; d1 = 3'd0; c1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        chk("reset0", pack(sel0, ld0, clro0, busy0, done0, err0, rdy0), pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
        chk("reset1", pack(sel1, ld1, clro1, busy1, done1, err1, rdy1), pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
        mon0 = 1'b1;
        mon1 = 1'b1;

        for (int i = 0; i < 17; i++) begin
            v0 = tbl[i].v; s0 = tbl[i].s; d0 = tbl[i].d; c0 = tbl[i].c;
            step();
            chk($sformatf("vec%0d", i), pack(sel0, ld0, clro0, busy0, done0, err0, rdy0), tbl[i].exp);
        end
        v0 = 1'b0;

        // Reset asserted during the LD cycle of src=M1 dst=M2.
        v0 = 1'b1; s0 = 3'd4; d0 = 3'd5; c0 = 1'b0;
        step();
        v0 = 1'b0;
        step();
        step();
        chk("mid_ld_state", pack(sel0, ld0, clro0, busy0, done0, err0, rdy0), pack(8'h10, 8'h20, 0, 1, 0, 0, 0));
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        chk("mid_reset", pack(sel0, ld0, clro0, busy0, done0, err0, rdy0), pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
        for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("post_reset%0d", j), pack(sel0, ld0, clro0, busy0, done0, err0, rdy0),
                pack(8'h00, 8'h00, 0, 0, 0, 0, 1));
        end

        // Parameter sweep: SETTLE=3 LOAD=2 HOLD=2, src=C dst=B.
        v1 = 1'b1; s1 = 3'd2; d1 = 3'd1; c1 = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            step();
            v1 = 1'b0;
            chk($sformatf("sweep_c%0d", j), pack(sel1, ld1, clro1, busy1, done1, err1, rdy1),
                pack((j <= 7) ? 8'h04 : 8'h00,
                     (j == 4 || j == 5) ? 8'h02 : 8'h00,
                     1'b0, (j <= 7), (j == 7), 1'b0, (j >= 8)));
        end

        mon0 = 1'b0;
        mon1 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule

// File: doc/reg_move_sequencer.md
# reg_move_sequencer

Sequencer for the register unit's 8-bit register-to-register move (MOV) and register clear (SET-to-zero). It accepts one move request at a time over a valid/ready handshake. It then drives the one-hot `sel` and `ld` control lines of the eight register units (A, B, C, D, M1, M2, X, Y) in relay-safe order: select the source, let the data bus settle, load the destination, then hold the source briefly. It sits between the instruction decoder and the register units' control-bus inputs, and mirrors its activity on the LED bus.

## Interface

Parameters:
- `SETTLE`, default 2: cycles the source is selected before the load strobe. Must be ≥1.
- `LOAD`, default 1: cycles the load strobe is asserted. Must be ≥1.
- `HOLD`, default 1: cycles the source stays selected after the load strobe drops. Must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: the block can accept a request.
- `req_src` in 3: source register code. 0=A, 1=B, 2=C, 3=D, 4=M1, 5=M2, 6=X, 7=Y.
- `req_dst` in 3: destination register code, same encoding.
- `req_clr` in 1: clear the destination; `req_src` is ignored.
- `sel_o` out 8: one-hot source select; bit i drives `selX` of register code i.
- `ld_o` out 8: one-hot destination load; bit i drives `ldX` of register code i.
- `clr_o` out 1: drive zero onto the data bus, used in place of a source select.
- `busy` out 1: a move is in progress.
- `done` out 1: one-cycle pulse marking the final cycle of a move.
- `err` out 1: one-cycle pulse for a rejected request.

## Operation

- Accept: a request is accepted on a cycle where `req_valid && req_ready`. `req_src`, `req_dst` and `req_clr` are captured on that edge. Later input changes have no effect on the move in progress.
- States and transitions:
  - IDLE → SEL when an accepted request is legal.
  - IDLE → ERR when `req_src == req_dst` and `req_clr == 0`.
  - SEL → LD after `SETTLE` cycles.
  - LD → HLD after `LOAD` cycles.
  - HLD → IDLE after `HOLD` cycles.
  - ERR → IDLE after exactly 1 cycle.
- Outputs by state:
  - IDLE: `req_ready`=1. All other outputs 0.
  - SEL: source bit of `sel_o` set (or `clr_o`=1 if a clear). `busy`=1.
  - LD: as SEL, plus destination bit of `ld_o` set.
  - HLD: as SEL, with `ld_o`=0. `done`=1 on the last HLD cycle only.
  - ERR: `err`=1. `busy`=0, `req_ready`=0. No `sel_o`, `ld_o` or `clr_o` activity.
- Invariants:
  - `sel_o` and `ld_o` are each zero or one-hot.
  - `ld_o` is never asserted unless a source (`sel_o` or `clr_o`) has been driving the bus for ≥`SETTLE` prior cycles.
  - `sel_o` and `clr_o` are never asserted together.
- Clear: a clear request with `req_src == req_dst` is legal, because `src` is ignored.
- LED mirroring: the LED bus mirrors `sel_o` and `ld_o` bit-for-bit, combinationally from the registered outputs.
- Phase counter: a single down-counter, width ⌈log2(max(SETTLE, LOAD, HOLD)+1)⌉. It is reloaded on each state entry.

## Timing

- All outputs are registered; no output depends combinationally on request inputs.
- Reset values: `req_ready`=1; `sel_o`, `ld_o`, `clr_o`, `busy`, `done`, `err` all 0; state IDLE.
- Accept on edge k (legal request):
  - `sel_o` valid cycles k+1 … k+SETTLE.
  - `ld_o` also valid cycles k+SETTLE+1 … k+SETTLE+LOAD.
  - `sel_o` only, cycles through k+SETTLE+LOAD+HOLD.
  - `done` is high in cycle k+SETTLE+LOAD+HOLD.
  - `req_ready` returns to 1 the following cycle.
- Move latency, accept to `done`: SETTLE+LOAD+HOLD cycles. Default is 4.
- Throughput: one move per SETTLE+LOAD+HOLD+1 cycles. There is no back-to-back acceptance in the `done` cycle.
- Rejected request: `err` is high in cycle k+1; `req_ready`=1 again in cycle k+2.
- `req_valid` while busy: ignored, not queued. The requester holds it until `req_ready`.
- Reset mid-move, including during LD: all outputs are 0 from the next cycle. `done` is not pulsed, and no partial load is completed.

## Test plan

- Reset with defaults: hold `reset` for 2 cycles, then check `req_ready`=1 and all other outputs 0.
- Legal move, defaults: request src=1 (B), dst=0 (A). Expect:
  - `sel_o`=8'h02 for 2 cycles;
  - then `sel_o`=8'h02 with `ld_o`=8'h01 for 1 cycle;
  - then `sel_o`=8'h02 with `done`=1 for 1 cycle;
  - then IDLE.
- Clear: request `req_clr`=1, dst=7 (Y), src=7. Expect `clr_o`=1 for 4 cycles, `ld_o`=8'h80 in cycle 3, `sel_o`=0 throughout, and `done` in cycle 4.
- Illegal move: request src=3, dst=3, `req_clr`=0. Expect `err`=1 for exactly 1 cycle, no `sel_o`/`ld_o` activity, and `req_ready`=1 two cycles after accept.
- Busy handling and reset mid-move:
  - Request src=6, dst=4 while a move is in progress: expect no effect on outputs.
  - Accept src=4, dst=5 and assert `reset` in the LD cycle: expect `ld_o`=0 and `sel_o`=0 the next cycle, no `done`, and `req_ready`=1.
- Parameter sweep: with SETTLE=3, LOAD=2, HOLD=2 and src=2, dst=1, expect `ld_o`=8'h02 exactly in cycles 4–5 after accept, `done` in cycle 7, and the one-hot and settle invariants checked by assertion every cycle.
